// File: rtl/drec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drec_pkg
//  Description : Shared types and constants for the multi-channel recorder.
//  Revision    : 1.0 - initial release
// ============================================================================
package drec_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC_WAIT  = 3'd1,
    S_REC_WR    = 3'd2,
    S_PLAY_WAIT = 3'd3,
    S_PLAY_RD   = 3'd4,
    S_PLAY_DATA = 3'd5
  } state_t;

  localparam logic [1:0] MODE_STANDBY = 2'd0;
  localparam logic [1:0] MODE_RECORD  = 2'd1;
  localparam logic [1:0] MODE_PLAY    = 2'd2;

  localparam int BTN_REC  = 0;
  localparam int BTN_PLAY = 1;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drec_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : drec_addr_gen
//  Description : Frame/channel counters producing the interleaved SDRAM address.
//  Revision    : 1.0 - initial release
// ============================================================================
module drec_addr_gen
  import drec_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int NCH    = 2,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              adv_i,
  output logic [CH_W-1:0]   ch_o,
  output logic [ADDR_W:0]   frame_inc_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_ch_o,
  output logic              last_frame_o
);

  localparam int FRM_W = ADDR_W + 1;
  localparam longint unsigned MAX_FRAMES = (64'd1 << ADDR_W) / 64'(NCH);

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic [ADDR_W-1:0] base_q, base_d;

  assign last_ch_o    = (ch_q == CH_W'(NCH - 1));
  assign last_frame_o = (frame_q == FRM_W'(MAX_FRAMES - 1));
  assign frame_inc_o  = frame_q + FRM_W'(1);
  // base tracks frame*NCH incrementally so no multiplier is needed
  assign addr_o       = base_q + ADDR_W'(ch_q);
  assign ch_o         = ch_q;

  always_comb begin
    ch_d    = ch_q;
    frame_d = frame_q;
    base_d  = base_q;
    if (clear_i) begin
      ch_d    = '0;
      frame_d = '0;
      base_d  = '0;
    end else if (adv_i) begin
      if (last_ch_o) begin
        ch_d    = '0;
        frame_d = frame_inc_o;
        base_d  = base_q + ADDR_W'(NCH);
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q    <= '0;
      frame_q <= '0;
      base_q  <= '0;
    end else begin
      ch_q    <= ch_d;
      frame_q <= frame_d;
      base_q  <= base_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/drec_multi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : drec_multi_controller
//  Description : Multi-channel record/playback controller between ADC, DAC and SDRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module drec_multi_controller
  import drec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 22,
  parameter int NCH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            button_i,
  input  logic                  loop_en_i,
  input  logic [NCH*DATA_W-1:0] adc_data_i,
  input  logic                  adc_enable_i,
  input  logic                  dac_tick_i,
  output logic [NCH*DATA_W-1:0] dac_data_o,
  output logic                  dac_enable_o,
  output logic [DATA_W-1:0]     sdram_wr_data_o,
  output logic [ADDR_W-1:0]     sdram_wr_addr_o,
  output logic                  sdram_wr_enable_o,
  input  logic                  sdram_wr_ready_i,
  output logic [ADDR_W-1:0]     sdram_rd_addr_o,
  output logic                  sdram_rd_enable_o,
  input  logic                  sdram_rd_ready_i,
  input  logic [DATA_W-1:0]     sdram_rd_data_i,
  input  logic                  sdram_rd_rdy_i,
  output logic [1:0]            mode_o,
  output logic [ADDR_W-1:0]     rec_frames_o,
  output logic                  overrun_o,
  output logic                  underrun_o
);

  localparam int CH_W    = ch_width(NCH);
  localparam int FRAME_W = NCH * DATA_W;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic                stop_q;
  logic [FRAME_W-1:0]  adc_q;
  logic [FRAME_W-1:0]  buf_q;
  logic [FRAME_W-1:0]  dac_data_q;
  logic                dac_en_q;
  logic                wr_en_q;
  logic                rd_en_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ADDR_W-1:0]   rec_frames_q;
  logic                overrun_q;
  logic                underrun_q;

  logic                w_ag_clear;
  logic                w_ag_adv;
  logic [CH_W-1:0]     w_ch;
  logic [ADDR_W:0]     w_frame_inc;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_last_ch;
  logic                w_last_frame;
  logic [FRAME_W-1:0]  w_play_frame;

  wire w_btn_any  = |button_i;
  wire w_btn_rec  = button_i[BTN_REC] & ~button_i[BTN_PLAY];
  wire w_btn_play = button_i[BTN_PLAY] & ~button_i[BTN_REC];
  wire w_wr_acc   = wr_en_q & sdram_wr_ready_i;
  wire w_rd_acc   = rd_en_q & sdram_rd_ready_i;
  wire w_play_end = (w_frame_inc == {1'b0, rec_frames_q});
  wire w_stopping = stop_q | w_btn_any;

  drec_addr_gen #(
    .ADDR_W (ADDR_W),
    .NCH    (NCH),
    .CH_W   (CH_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_ag_clear),
    .adv_i        (w_ag_adv),
    .ch_o         (w_ch),
    .frame_inc_o  (w_frame_inc),
    .addr_o       (w_addr),
    .last_ch_o    (w_last_ch),
    .last_frame_o (w_last_frame)
  );

  // The final channel goes to the DAC straight from the read bus.
  always_comb begin
    w_play_frame = buf_q;
    w_play_frame[FRAME_W-1 -: DATA_W] = sdram_rd_data_i;
  end

  always_comb begin
    w_ag_clear = 1'b0;
    w_ag_adv   = 1'b0;
    case (state_q)
      S_IDLE:
        if (w_btn_rec || (w_btn_play && rec_frames_q != '0)) w_ag_clear = 1'b1;
      S_REC_WR:
        if (w_wr_acc) w_ag_adv = 1'b1;
      S_PLAY_DATA:
        if (sdram_rd_rdy_i && !w_btn_any) begin
          if (w_last_ch && w_play_end && loop_en_i) w_ag_clear = 1'b1;
          else                                      w_ag_adv   = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_STANDBY;
      stop_q       <= 1'b0;
      adc_q        <= '0;
      buf_q        <= '0;
      dac_data_q   <= '0;
      dac_en_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_data_q    <= '0;
      rec_frames_q <= '0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      dac_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_btn_rec) begin
            state_q      <= S_REC_WAIT;
            mode_q       <= MODE_RECORD;
            stop_q       <= 1'b0;
            rec_frames_q <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
          end else if (w_btn_play && rec_frames_q != '0) begin
            state_q    <= S_PLAY_WAIT;
            mode_q     <= MODE_PLAY;
            stop_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
          end
        end

        S_REC_WAIT: begin
          if (w_btn_any) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_STANDBY;
          end else if (adc_enable_i) begin
            adc_q     <= adc_data_i;
            wr_data_q <= adc_data_i[DATA_W-1:0];
            wr_en_q   <= 1'b1;
            state_q   <= S_REC_WR;
          end
        end

        S_REC_WR: begin
          if (adc_enable_i) overrun_q <= 1'b1;
          if (w_btn_any)    stop_q    <= 1'b1;
          if (w_wr_acc) begin
            if (w_last_ch) begin
              wr_en_q      <= 1'b0;
              rec_frames_q <= w_frame_inc[ADDR_W-1:0];
              if (w_stopping || w_last_frame) begin
                state_q <= S_IDLE;
                mode_q  <= MODE_STANDBY;
              end else begin
                state_q <= S_REC_WAIT;
              end
            end else if (w_stopping) begin
              // partial frame: abandon remaining channels, count unchanged
              wr_en_q <= 1'b0;
              state_q <= S_IDLE;
              mode_q  <= MODE_STANDBY;
            end else begin
              wr_data_q <= adc_q[(int'(w_ch) + 1) * DATA_W +: DATA_W];
            end
          end
        end

        S_PLAY_WAIT: begin
          if (w_btn_any) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_STANDBY;
          end else if (dac_tick_i) begin
            rd_en_q <= 1'b1;
            state_q <= S_PLAY_RD;
          end
        end

        S_PLAY_RD: begin
          if (dac_tick_i) underrun_q <= 1'b1;
          if (w_btn_any)  stop_q     <= 1'b1;
          if (w_rd_acc) begin
            rd_en_q <= 1'b0;
            if (w_stopping) begin
              state_q <= S_IDLE;
              mode_q  <= MODE_STANDBY;
            end else begin
              state_q <= S_PLAY_DATA;
            end
          end
        end

        S_PLAY_DATA: begin
          if (dac_tick_i) underrun_q <= 1'b1;
          if (w_btn_any) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_STANDBY;
          end else if (sdram_rd_rdy_i) begin
            buf_q[int'(w_ch) * DATA_W +: DATA_W] <= sdram_rd_data_i;
            if (!w_last_ch) begin
              rd_en_q <= 1'b1;
              state_q <= S_PLAY_RD;
            end else begin
              dac_data_q <= w_play_frame;
              dac_en_q   <= 1'b1;
              if (w_play_end && !loop_en_i) begin
                state_q <= S_IDLE;
                mode_q  <= MODE_STANDBY;
              end else begin
                state_q <= S_PLAY_WAIT;
              end
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          mode_q  <= MODE_STANDBY;
        end
      endcase
    end
  end

  assign dac_data_o        = dac_data_q;
  assign dac_enable_o      = dac_en_q;
  assign sdram_wr_data_o   = wr_data_q;
  assign sdram_wr_addr_o   = w_addr;
  assign sdram_wr_enable_o = wr_en_q;
  assign sdram_rd_addr_o   = w_addr;
  assign sdram_rd_enable_o = rd_en_q;
  assign mode_o            = mode_q;
  assign rec_frames_o      = rec_frames_q;
  assign overrun_o         = overrun_q;
  assign underrun_o        = underrun_q;

endmodule
`default_nettype wire
